riscv_dmem_responder: RTL

- Memory-side responder for the pipelined RISC-V core's load/store port.
- Accepts one request at a time over a valid/ready channel and performs the byte, half or word access on an internal word-organised RAM.
- Returns load data or an error over a valid/ready response channel, after a configurable number of wait states.
- Lets the pipeline's stall and hazard logic be exercised against non-zero memory latency.

---
 rtl/riscv_dmem_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a
// time, configurable wait states, byte/half/word access on a word RAM.
module riscv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  logic        a_write, a_uns;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;

  logic        s_write, s_uns;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_size;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      word;
  logic [IDX_W-1:0] idx;
  logic [4:0]       shamt;
  logic             bad;
  logic [3:0]       be;
  logic [31:0]      rd_word, rd_shift, ld_data, wr_shift, wr_word;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // Access operands: with zero wait states the commit happens on the
  // handshake edge itself, so the live request is used instead of the latch.
  always_comb begin
    if (state_q == IDLE) begin
      s_write = req_write;
      s_addr  = req_addr;
      s_size  = req_size;
      s_uns   = req_unsigned;
      s_wdata = req_wdata;
    end else begin
      s_write = a_write;
      s_addr  = a_addr;
      s_size  = a_size;
      s_uns   = a_uns;
      s_wdata = a_wdata;
    end
  end

  // Error check, load extraction and store byte-lane merge.
  always_comb begin
    word     = s_addr[31:2];
    idx      = word[IDX_W-1:0];
    shamt    = {s_addr[1:0], 3'b000};
    bad      = 1'b0;
    case (s_size)
      2'b01:   bad = s_addr[0];
      2'b10:   bad = |s_addr[1:0];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (word >= 30'(DEPTH_WORDS)) bad = 1'b1;

    rd_word  = mem[idx];
    rd_shift = rd_word >> shamt;
    case (s_size)
      2'b00:   ld_data = s_uns ? {24'h0, rd_shift[7:0]}
                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = s_uns ? {16'h0, rd_shift[15:0]}
                               : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase

    case (s_size)
      2'b00:   be = 4'b0001 << s_addr[1:0];
      2'b01:   be = 4'b0011 << s_addr[1:0];
      default: be = 4'b1111;
    endcase
    wr_shift = s_wdata << shamt;
    wr_word  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? wr_shift[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_size    <= '0;
      a_uns     <= 1'b0;
      a_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        a_write <= req_write;
        a_addr  <= req_addr;
        a_size  <= req_size;
        a_uns   <= req_unsigned;
        a_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_rdata <= (bad || s_write) ? '0 : ld_data;
        rsp_err   <= bad;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && s_write && !bad) mem[idx] <= wr_word;
  end

endmodule
